// File: rtl/i2s_tx.sv
// ============================================================================
//  Module   : i2s_tx
//  Purpose  : I2S transmitter, 64 SCK per frame, 32-bit slots, MSB first,
//             one sample of buffering per channel. Optional macro
//             I2S_TX_HOLD_LAST_EN repeats a channel's last sample on underrun.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module i2s_tx #(
   parameter int CLK_FREQ = 27_000_000,
   parameter int SCK_FREQ = 2_700_000,
   parameter int SAMPLE_W = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [SAMPLE_W-1:0] data_i,
   input  logic                lr_i,
   input  logic                data_valid_i,
   output logic                data_ready_o,
   output logic                sck_o,
   output logic                ws_o,
   output logic                sd_o,
   output logic                underrun_o
);

   localparam int c_HALF  = CLK_FREQ / (2 * SCK_FREQ);
   localparam int c_DIV_W = (c_HALF > 1) ? $clog2(c_HALF) : 1;
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_HALF - 1);

   generate
      if (c_HALF < 2) begin : g_half_check
         $error("i2s_tx: CLK_FREQ/(2*SCK_FREQ) must be at least 2");
      end
   endgenerate

   // Left-align a sample in a 32-bit slot so zero padding follows the LSB.
   function automatic logic [31:0] f_align(input logic [SAMPLE_W-1:0] s);
      return 32'(s) << (32 - SAMPLE_W);
   endfunction

   logic [c_DIV_W-1:0]  r_div_cnt;
   logic                r_sck;
   logic [5:0]          r_pos;
   logic                r_ws;
   logic                r_sd;
   logic                r_underrun;
   logic [1:0]          r_full;
   logic [SAMPLE_W-1:0] r_hold_l;
   logic [SAMPLE_W-1:0] r_hold_r;
   logic [31:0]         r_sh_l;
   logic [31:0]         r_sh_r;

   logic                w_fall;
   logic [5:0]          w_pos_nx;
   logic                w_load_l;
   logic                w_load_r;
   logic                w_wr;
   logic [SAMPLE_W-1:0] w_fill_l;
   logic [SAMPLE_W-1:0] w_fill_r;
   logic [SAMPLE_W-1:0] w_smp_l;
   logic [SAMPLE_W-1:0] w_smp_r;
   logic [31:0]         w_slot_l;
   logic [31:0]         w_slot_r;

`ifdef I2S_TX_HOLD_LAST_EN
   logic [SAMPLE_W-1:0] r_last_l;
   logic [SAMPLE_W-1:0] r_last_r;

   assign w_fill_l = r_last_l;
   assign w_fill_r = r_last_r;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_last_l <= '0;
         r_last_r <= '0;
      end else begin
         if (w_load_l) r_last_l <= w_smp_l;
         if (w_load_r) r_last_r <= w_smp_r;
      end
   end
`else
   assign w_fill_l = '0;
   assign w_fill_r = '0;
`endif

   assign w_fall       = r_sck && (r_div_cnt == c_DIV_LAST);
   assign w_pos_nx     = r_pos + 6'd1;
   assign w_load_l     = w_fall && (w_pos_nx == 6'd1);
   assign w_load_r     = w_fall && (w_pos_nx == 6'd33);
   assign data_ready_o = lr_i ? ~r_full[1] : ~r_full[0];
   assign w_wr         = data_valid_i && data_ready_o;

   // Full flag is the pre-write value, so a same-cycle write still underruns.
   assign w_smp_l  = r_full[0] ? r_hold_l : w_fill_l;
   assign w_smp_r  = r_full[1] ? r_hold_r : w_fill_r;
   assign w_slot_l = f_align(w_smp_l);
   assign w_slot_r = f_align(w_smp_r);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_div_cnt <= '0;
         r_sck     <= 1'b0;
      end else if (r_div_cnt == c_DIV_LAST) begin
         r_div_cnt <= '0;
         r_sck     <= ~r_sck;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pos      <= '0;
         r_ws       <= 1'b0;
         r_sd       <= 1'b0;
         r_underrun <= 1'b0;
         r_sh_l     <= '0;
         r_sh_r     <= '0;
      end else begin
         r_underrun <= 1'b0;
         if (w_fall) begin
            r_pos <= w_pos_nx;
            r_ws  <= w_pos_nx[5];
            if (w_load_l) begin
               r_sd       <= w_slot_l[31];
               r_sh_l     <= w_slot_l << 1;
               r_underrun <= ~r_full[0];
            end else if (w_load_r) begin
               r_sd       <= w_slot_r[31];
               r_sh_r     <= w_slot_r << 1;
               r_underrun <= ~r_full[1];
            end else if (w_pos_nx >= 6'd2 && w_pos_nx <= 6'd32) begin
               r_sd   <= r_sh_l[31];
               r_sh_l <= r_sh_l << 1;
            end else begin
               r_sd   <= r_sh_r[31];
               r_sh_r <= r_sh_r << 1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_full   <= '0;
         r_hold_l <= '0;
         r_hold_r <= '0;
      end else begin
         if (w_wr && !lr_i) begin
            r_full[0] <= 1'b1;
            r_hold_l  <= data_i;
         end else if (w_load_l) begin
            r_full[0] <= 1'b0;
         end
         if (w_wr && lr_i) begin
            r_full[1] <= 1'b1;
            r_hold_r  <= data_i;
         end else if (w_load_r) begin
            r_full[1] <= 1'b0;
         end
      end
   end

   assign sck_o      = r_sck;
   assign ws_o       = r_ws;
   assign sd_o       = r_sd;
   assign underrun_o = r_underrun;

endmodule

`default_nettype wire

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 27_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter SCK_FREQ, default 2_700_000, meaning serial bit clock frequency in Hz.
REQ-003 SHALL have parameter SAMPLE_W, default 16, meaning sample width in bits (1..32).
REQ-004 SHALL have port clk_i  input  1  system clock; the block uses this single clock only.
REQ-005 SHALL have port rst_i  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port data_i  input  SAMPLE_W  parallel sample to transmit.
REQ-007 SHALL have port lr_i  input  1  channel tag of data_i: 0 = left, 1 = right.
REQ-008 SHALL have port data_valid_i  input  1  data_i/lr_i valid.
REQ-009 SHALL have port data_ready_o  output  1  holding register for the channel tagged by lr_i is empty.
REQ-010 SHALL have port sck_o  output  1  I2S bit clock.
REQ-011 SHALL have port ws_o  output  1  I2S word select: 0 = left, 1 = right.
REQ-012 SHALL have port sd_o  output  1  I2S serial data.
REQ-013 SHALL have port underrun_o  output  1  one-cycle pulse when a slot loads from an empty holding register.

Function
REQ-014 SHALL derive HALF = CLK_FREQ/(2*SCK_FREQ), which must be an integer of at least 2; default HALF = 5.
REQ-015 SHALL count div_cnt 0..HALF-1 and toggle sck_o in the cycle after div_cnt = HALF-1, giving a 2*HALF-cycle SCK period and 50% duty.
REQ-016 SHALL define a falling edge as the clk cycle in which sck_o changes 1->0; all ws_o/sd_o changes occur only on falling edges.
REQ-017 SHALL keep a 6-bit frame position p, incremented on each falling edge and wrapping 63->0 (64 SCK per frame, two 32-bit slots).
REQ-018 SHALL drive ws_o = 1 when p is in 32..63, else 0.
REQ-019 SHALL transmit left-slot bit j = p-1 for p in 1..32, and right-slot bit j = p-33 for p in 33..63 and p = 0 (j = 31); this delays data by one SCK after each ws_o edge, per I2S.
REQ-020 SHALL send slot bits j = 0..SAMPLE_W-1 as the sample MSB first, then zeros for j = SAMPLE_W..31.
REQ-021 SHALL hold one sample per channel in separate holding registers, each with a full flag.
REQ-022 SHALL derive data_ready_o combinationally as ~full[lr_i]; a write occurs when data_valid_i & data_ready_o and sets full[lr_i] on the next cycle.
REQ-023 SHALL load the left shift register from the left holding register on the falling edge where p becomes 1, and the right one on the falling edge where p becomes 33, clearing that channel's full flag.
REQ-024 SHALL, on a load with the channel's full flag clear, pulse underrun_o for 1 cycle and load the Configuration-defined fill value.
REQ-025 SHALL treat a write arriving in the same cycle as a load of an empty channel as an underrun; the written sample is kept for the next frame.
REQ-026 SHALL leave data_i/lr_i don't-care while data_valid_i = 0; a write with data_ready_o = 0 is ignored and causes no state change.

Reset
REQ-027 SHALL, while rst_i = 1 at a clk_i edge, clear div_cnt, p, sck_o, ws_o, sd_o, underrun_o, both full flags, both shift registers and both last-sample registers to 0.
REQ-028 SHALL, when rst_i is asserted mid-frame, abort the frame, discard held samples, and restart at p = 0 after release.
REQ-029 SHALL give the first falling edge 2*HALF cycles after reset release (p -> 1, left load).

Configuration
REQ-030 SHALL use macro I2S_TX_HOLD_LAST_EN: when defined, an underrun reloads that channel's last transmitted sample; when undefined, an underrun sends all-zero slot data.

Verification
REQ-031 SHALL cover reset then write L=16'hA5C3, R=16'h0F01 before the first falling edge -> sck_o period 10 cycles; sd_o on left bits j0..15 = 1010010111000011, j16..31 = 0; right slot = 0000111100000001; ws_o rises at p = 32; no underrun.
REQ-032 SHALL cover no writes after reset -> underrun_o pulses at p = 1 and p = 33 of each frame; sd_o stays 0 under both macro settings (last-sample registers reset to 0).
REQ-033 SHALL cover left = 16'h8001 in frame 1, then no left write -> frame 2 left slot = 16'h8001 with I2S_TX_HOLD_LAST_EN, 16'h0000 without; underrun_o pulses at frame-2 p = 1.
REQ-034 SHALL cover two left writes, the second offered while full -> data_ready_o = 0 for lr_i = 0 and 1 for lr_i = 1; the second sample is not stored until the load at p = 1 frees the register.
REQ-035 SHALL cover a left write in the exact load cycle of an empty left register -> underrun_o pulses; that sample is sent in the following frame.
REQ-036 SHALL cover rst_i asserted 1 cycle at p = 40 -> all outputs 0 next cycle, both full flags cleared, data_ready_o = 1, and frame timing restarts per REQ-029.
